// File: rtl/json_lexer.sv
// Byte-stream lexer feeding a JSON pair counter: strips whitespace outside strings,
// masks escape sequences as '_', and buffers cleaned characters in a 4-deep FIFO.
module json_lexer (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  input  logic       out_ready,
  output logic       esc_err,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_OUTSIDE = 2'd0,
    S_IN_STR  = 2'd1,
    S_ESC     = 2'd2
  } lex_state_e;

  localparam logic [7:0] CH_QUOTE = 8'h22;
  localparam logic [7:0] CH_BSL   = 8'h5C;
  localparam logic [7:0] CH_MASK  = 8'h5F;

  lex_state_e state_q, state_d;
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic [7:0] mem_q [4];
  logic       esc_err_q, esc_err_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  logic       accept, pop, push, drop;
  logic [7:0] push_char;

  assign in_ready  = (count_q != 3'd4);
  assign out_valid = (count_q != 3'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Gate the head so an empty FIFO presents 0x00 rather than stale storage.
  assign out_char  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign esc_err   = esc_err_q;
  assign drop_cnt  = drop_cnt_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    drop      = 1'b0;
    push_char = in_char;
    esc_err_d = esc_err_q;
    if (accept) begin
      unique case (state_q)
        S_OUTSIDE: begin
          if (in_char inside {8'h20, 8'h09, 8'h0A, 8'h0D}) begin
            drop = 1'b1;
          end else begin
            push = 1'b1;
            if (in_char == CH_QUOTE) state_d = S_IN_STR;
          end
        end
        S_IN_STR: begin
          if (in_char == CH_BSL) begin
            drop    = 1'b1;
            state_d = S_ESC;
          end else begin
            push = 1'b1;
            if (in_char == CH_QUOTE) state_d = S_OUTSIDE;
          end
        end
        S_ESC: begin
          push      = 1'b1;
          push_char = CH_MASK;
          state_d   = S_IN_STR;
          if (!(in_char inside {8'h22, 8'h5C, 8'h2F, 8'h62, 8'h66,
                                8'h6E, 8'h72, 8'h74, 8'h75})) begin
            esc_err_d = 1'b1;
          end
        end
        default: state_d = S_OUTSIDE;
      endcase
    end
  end

  always_comb begin
    drop_cnt_d = drop ? drop_cnt_q + 8'd1 : drop_cnt_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_OUTSIDE;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      esc_err_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      esc_err_q  <= esc_err_d;
      drop_cnt_q <= drop_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_char;
  end

endmodule

// File: tb/tb_json_lexer.sv
// Self-checking bench for json_lexer: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based lexing model.
module tb_json_lexer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready;
  logic       esc_err;
  logic [7:0] drop_cnt;

  json_lexer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_ready (out_ready),
    .esc_err   (esc_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lexical mode, buffered characters, counters.
  byte unsigned mq[$];
  byte unsigned rx[$];
  int           m_mode;   // 0 = outside string, 1 = inside string, 2 = after backslash
  logic [7:0]   m_drop;
  logic         m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_drop = 8'd0;
    m_err  = 1'b0;
  endtask

  function automatic bit is_ws(byte unsigned c);
    return (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D);
  endfunction

  function automatic bit is_legal_esc(byte unsigned c);
    return c inside {8'h22, 8'h5C, 8'h2F, 8'h62, 8'h66, 8'h6E, 8'h72, 8'h74, 8'h75};
  endfunction

  task automatic model_lex(input byte unsigned c);
    if (m_mode == 2) begin
      mq.push_back(8'h5F);
      if (!is_legal_esc(c)) m_err = 1'b1;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (c == 8'h5C) begin
        m_drop++;
        m_mode = 2;
      end else begin
        mq.push_back(c);
        if (c == 8'h22) m_mode = 0;
      end
    end else begin
      if (is_ws(c)) m_drop++;
      else begin
        mq.push_back(c);
        if (c == 8'h22) m_mode = 1;
      end
    end
  endtask

  // One clock: drive at negedge, compare settled outputs to the model, then advance both.
  task automatic step(input logic v, input byte unsigned c, input logic rdy);
    bit acc, pp;
    @(negedge clk);
    in_valid  = v;
    in_char   = c;
    out_ready = rdy;
    #1;
    check("in_ready",  in_ready,  mq.size() != 4);
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) check("out_char", out_char, mq[0]);
    check("drop_cnt", drop_cnt, m_drop);
    check("esc_err",  esc_err,  m_err);
    acc = v && (mq.size() != 4);
    pp  = rdy && (mq.size() != 0);
    if (pp) begin
      rx.push_back(out_char);
      void'(mq.pop_front());
    end
    if (acc) model_lex(c);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b1);
    repeat (5) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic check_seq(input string tag, input string exp);
    check({tag, "_len"}, rx.size(), exp.len());
    for (int i = 0; i < exp.len() && i < rx.size(); i++) check(tag, rx[i], exp[i]);
    rx.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_reset();
    rx.delete();
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_char",  out_char,  8'h00);
    check("rst_esc_err",   esc_err,   1'b0);
    check("rst_drop_cnt",  drop_cnt,  8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    byte unsigned pool[10];
    pool = '{8'h20, 8'h22, 8'h5C, 8'h61, 8'h6E, 8'h71, 8'h09, 8'h7B, 8'h3A, 8'h2F};
    reset = 1'b1; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
    model_reset();

    // Plain object: whitespace outside strings removed
    do_reset();
    send_str("{ \"a\" : \"b\" }");
    check_seq("obj_seq", "{\"a\":\"b\"}");
    check("obj_drop", drop_cnt, 8'd4);
    check("obj_err",  esc_err,  1'b0);

    // Escaped quote masked, lexer returns to outside: a trailing space is dropped
    do_reset();
    send_str("\"x\\\"y\"");
    check_seq("escq_seq", "\"x_y\"");
    check("escq_drop", drop_cnt, 8'd1);
    check("escq_err",  esc_err,  1'b0);
    step(1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("escq_outside_drop",  drop_cnt,  8'd2);
    check("escq_outside_empty", out_valid, 1'b0);

    // Illegal escape sets a sticky error
    do_reset();
    send_str("\"\\q\"");
    check_seq("bad_seq", "\"_\"");
    check("bad_err", esc_err, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, pool[$urandom_range(0, 9)], 1'b1);
      check("bad_err_sticky", esc_err, 1'b1);
    end
    repeat (5) step(1'b0, 8'h00, 1'b1);
    rx.delete();

    // Backpressure: only 4 of 6 bytes accepted, head held stable
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h41 + i, 1'b0);
      check("bp_head", out_char, 8'h41);
      check("bp_in_ready", in_ready, (i < 3) ? 1'b1 : 1'b0);
    end
    repeat (6) step(1'b0, 8'h00, 1'b1);
    check_seq("bp_seq", "ABCD");

    // 256 spaces: drop counter wraps, nothing buffered
    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("wrap_drop",  drop_cnt,  8'd0);
    check("wrap_empty", out_valid, 1'b0);

    // Reset in the middle of an escape with 3 bytes buffered
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, (i == 0) ? 8'h22 : (i == 3) ? 8'h5C : 8'h60 + i, 1'b0);
    check("mid_buffered", out_valid, 1'b1);
    check("mid_drop", drop_cnt, 8'd1);
    do_reset();
    step(1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("mid_after_drop",  drop_cnt,  8'd1);
    check("mid_after_empty", out_valid, 1'b0);

    // Randomized traffic with random valid/ready against the model
    do_reset();
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, pool[$urandom_range(0, 9)], ($urandom % 3) != 0);
    repeat (6) step(1'b0, 8'h00, 1'b1);
    check("rand_drained", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/json_lexer.md
JSON_LEXER -- requirements
Module: json_lexer

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  input  1  raw byte present on in_char this cycle.
REQ-005 in_char  input  8  raw ASCII byte from source.
REQ-006 in_ready  output  1  lexer can accept a byte; transfer occurs when in_valid && in_ready at posedge clk.
REQ-007 out_valid  output  1  cleaned character present on out_char.
REQ-008 out_char  output  8  cleaned character for the downstream pair counter.
REQ-009 out_ready  input  1  downstream consumes out_char when out_valid && out_ready at posedge clk.
REQ-010 esc_err  output  1  sticky flag: an illegal escape sequence was seen.
REQ-011 drop_cnt  output  8  count of bytes discarded as whitespace or escape backslash, wraps modulo 256.

Function
REQ-012 SHALL keep a lexical state machine with states OUTSIDE, IN_STR and ESC, advanced only on accepted input bytes.
REQ-013 OUTSIDE: bytes 0x20, 0x09, 0x0A and 0x0D SHALL be dropped; all other bytes SHALL be pushed; 0x22 (") SHALL push and move to IN_STR.
REQ-014 IN_STR: 0x22 SHALL push and move to OUTSIDE; 0x5C (\) SHALL be dropped and move to ESC; all other bytes, including whitespace, SHALL be pushed unchanged.
REQ-015 ESC: the accepted byte SHALL push as 0x5F (_) so string length is kept and an escaped quote never reaches downstream as 0x22; the state then returns to IN_STR.
REQ-016 ESC: if the byte is not one of " \ / b f n r t u, esc_err SHALL set to 1 and stay at 1 until reset; the 0x5F push still occurs.
REQ-017 Each dropped byte SHALL increment drop_cnt by 1, wrapping from 255 to 0.
REQ-018 Pushed characters SHALL enter a 4-entry FIFO with 2-bit pointers that wrap modulo 4 and a 3-bit occupancy count from 0 to 4.
REQ-019 in_ready SHALL equal (count != 4); when full, no byte is accepted, even if a pop occurs in the same cycle.
REQ-020 out_valid SHALL equal (count != 0); out_char SHALL be the FIFO head and SHALL be held stable while out_valid && !out_ready.
REQ-021 Simultaneous push and pop with 0 < count < 4 SHALL leave count unchanged and advance both pointers.
REQ-022 A pop when count == 0 SHALL NOT occur; out_ready alone has no effect.
REQ-023 Latency SHALL be one cycle: a byte pushed at edge N appears on out_char after edge N when the FIFO was empty.
REQ-024 A dropped byte SHALL NOT change FIFO contents, count or out_valid.
REQ-025 Characters SHALL leave the FIFO in acceptance order with no reordering or duplication.

Reset
REQ-026 On reset the lexer SHALL set state to OUTSIDE, set FIFO pointers and count to 0, and set out_valid=0, out_char=0x00, in_ready=1, esc_err=0 and drop_cnt=0.
REQ-027 Reset asserted mid-string or mid-escape SHALL discard buffered characters; the first byte accepted after release is lexed in OUTSIDE.
REQ-028 in_ready SHALL be 1 from the first cycle after reset release.

Verification
REQ-029 Send `{ "a" : "b" }` with out_ready=1 -> out_char sequence { " a " : " b " }, drop_cnt=4, esc_err=0.
REQ-030 Send `"x\"y"` -> out_char sequence " x _ y ", drop_cnt=1, esc_err=0, final state OUTSIDE.
REQ-031 Send `"\q"` -> out_char sequence " _ ", esc_err=1, and esc_err stays 1 through 10 further bytes until reset.
REQ-032 Hold out_ready=0 with in_valid=1 for 6 non-space bytes -> exactly 4 accepted, in_ready=0 from the 4th acceptance onward, out_char stable at the first byte; with out_ready=1, the 4 bytes drain in order.
REQ-033 Send 256 spaces in OUTSIDE -> drop_cnt wraps to 0 and out_valid stays 0 throughout.
REQ-034 Assert reset while in ESC with 3 bytes buffered -> count=0, out_valid=0, state OUTSIDE; a following 0x20 is dropped, not pushed.
